rv_timer_sched: RTL and testbench

Timing engine and compare scheduler behind the rv_timer register file. Runs one tick prescaler per hart and produces the mtime increment write-backs. A single shared 64-bit unsigned comparator is time-multiplexed across all harts, and it raises interrupt-set pulses. All outputs connect to the register block's hw2reg fields (timer_v de/d, intr_state de/d). Configuration and current values come from its reg2hw/qs fields.

---
 rtl/rv_timer_pkg.sv | 15 +
 rtl/rv_timer_prescaler.sv | 31 +++
 rtl/rv_timer_sched.sv | 136 +++++++++++++
 tb/tb_rv_timer_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_timer_pkg.sv
// Shared constants and scheduler state type
// for the rv_timer timing engine.
package rv_timer_pkg;

   localparam int MAX_HARTS = 16;
   localparam int MTIME_W   = 64;
   localparam int PW_DEF    = 12;
   localparam int SW_DEF    = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } sched_state_t;

endpackage

// File: rtl/rv_timer_prescaler.sv
// Per-hart tick prescaler: counts 0..prescale,
// ticks and wraps when the count reaches prescale.
module rv_timer_prescaler
   import rv_timer_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          active_i,
   input  logic [PW-1:0] prescale_i,
   output logic          tick_o
);

   logic [PW-1:0] count;

   // >= so a prescale lowered below the count ticks at once
   assign tick_o = active_i && (count >= prescale_i);

   // count advances while active, clears on tick or when idle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (!active_i || tick_o) begin
         count <= '0;
      end else begin
         count <= count + PW'(1);
      end
   end

endmodule

// File: rtl/rv_timer_sched.sv
// Timing engine: per-hart prescalers, mtime increment
// write-back and a shared round-robin 64-bit comparator.
module rv_timer_sched
   import rv_timer_pkg::*;
#(
   parameter  int N_HARTS = 1,
   parameter  int PW      = PW_DEF,
   parameter  int SW      = SW_DEF,
   localparam int SELW    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_HARTS-1:0]         active_i,
   input  logic [N_HARTS*PW-1:0]      prescale_i,
   input  logic [N_HARTS*SW-1:0]      step_i,
   input  logic [N_HARTS*MTIME_W-1:0] mtime_i,
   input  logic [N_HARTS*MTIME_W-1:0] mtimecmp_i,
   input  logic [N_HARTS-1:0]         cmp_upd_i,
   output logic [N_HARTS*MTIME_W-1:0] mtime_o,
   output logic [N_HARTS-1:0]         mtime_we_o,
   output logic [N_HARTS-1:0]         intr_o,
   output logic [SELW-1:0]            sel_o
);

   sched_state_t       state;
   logic [N_HARTS-1:0] tick;
   logic [N_HARTS-1:0] pending;
   logic [N_HARTS-1:0] pend_act;
   logic [N_HARTS-1:0] rot;
   logic [SELW-1:0]    rr_ptr;
   logic [SELW-1:0]    sel_pend;
   logic [SELW-1:0]    sel_rr;
   logic [SELW-1:0]    sel;
   logic [SELW-1:0]    rr_next;
   logic [SELW:0]      sum;
   logic               use_pend;
   logic               found;
   logic               eval;
   logic               hit;

   for (genvar h = 0; h < N_HARTS; h++) begin : g_pre
      rv_timer_prescaler #(
         .PW(PW)
      ) u_pre (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .active_i   (active_i[h]),
         .prescale_i (prescale_i[h*PW +: PW]),
         .tick_o     (tick[h])
      );
   end

   assign pend_act = pending & active_i;
   // active mask rotated so bit 0 is the hart at rr_ptr
   assign rot = N_HARTS'({active_i, active_i} >> rr_ptr);
   assign eval = (state == ST_SCAN) && (|active_i);

   // lowest-index hart that is both active and pending
   always_comb begin
      sel_pend = '0;
      use_pend = 1'b0;
      for (int i = N_HARTS - 1; i >= 0; i--) begin
         if (pend_act[i]) begin
            sel_pend = SELW'(i);
            use_pend = 1'b1;
         end
      end
   end

   // first active hart at or after rr_ptr, circularly
   always_comb begin
      sel_rr = '0;
      found  = 1'b0;
      sum    = '0;
      for (int i = 0; i < N_HARTS; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum = {1'b0, rr_ptr} + (SELW+1)'(i);
            if (sum >= (SELW+1)'(N_HARTS)) begin
               sum = sum - (SELW+1)'(N_HARTS);
            end
            sel_rr = sum[SELW-1:0];
         end
      end
   end

   assign sel = use_pend ? sel_pend : sel_rr;
   assign rr_next = use_pend ? rr_ptr :
                    (sel == SELW'(N_HARTS - 1)) ? '0 :
                    sel + SELW'(1);
   assign hit = mtime_i[sel*MTIME_W +: MTIME_W] >=
                mtimecmp_i[sel*MTIME_W +: MTIME_W];

   // scheduler state, pending flags and compare result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         pending <= '0;
         rr_ptr  <= '0;
         sel_o   <= '0;
         intr_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|active_i) state <= ST_SCAN;
            ST_SCAN: if (!(|active_i)) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         intr_o  <= '0;
         pending <= pending | cmp_upd_i;
         if (eval) begin
            rr_ptr <= rr_next;
            sel_o  <= sel;
            if (hit) intr_o <= N_HARTS'(1) << sel;
            if (!cmp_upd_i[sel]) pending[sel] <= 1'b0;
         end
      end
   end

   // registered mtime write-back on each tick
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mtime_o    <= '0;
         mtime_we_o <= '0;
      end else begin
         mtime_we_o <= tick;
         for (int h = 0; h < N_HARTS; h++) begin
            if (tick[h]) begin
               mtime_o[h*MTIME_W +: MTIME_W] <=
                  mtime_i[h*MTIME_W +: MTIME_W] +
                  MTIME_W'(step_i[h*SW +: SW]);
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_timer_sched.sv
// Self-checking bench for rv_timer_sched (4 harts):
// directed scenarios plus randomized traffic vs. a model.
module tb_rv_timer_sched;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   active;
   logic [47:0]  prescale;
   logic [31:0]  step;
   logic [255:0] mtime_in;
   logic [255:0] cmp_in;
   logic [3:0]   upd;
   logic [255:0] mtime_o;
   logic [3:0]   we_o;
   logic [3:0]   intr_o;
   logic [1:0]   sel_o;

   int checks = 0;
   int errors = 0;

   int          cnt[4];
   bit          pend[4];
   bit          scan;
   int          rr;
   logic [3:0]  exp_we;
   logic [3:0]  exp_intr;
   logic [63:0] exp_mt[4];
   int          exp_sel;
   bit          chk_sel;
   bit          exp_rst;

   always #5 clk = ~clk;

   rv_timer_sched #(
      .N_HARTS (N),
      .PW      (12),
      .SW      (8)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .active_i   (active),
      .prescale_i (prescale),
      .step_i     (step),
      .mtime_i    (mtime_in),
      .mtimecmp_i (cmp_in),
      .cmp_upd_i  (upd),
      .mtime_o    (mtime_o),
      .mtime_we_o (we_o),
      .intr_o     (intr_o),
      .sel_o      (sel_o)
   );

   task automatic chk(string name, logic [63:0] got,
                      logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h",
                  name, got, exp);
      end
   endtask

   // what the outputs must be after the coming edge
   task automatic model_step();
      int  s;
      bit  bypend;
      bit  ev;
      exp_we   = '0;
      exp_intr = '0;
      chk_sel  = 1'b0;
      exp_rst  = rst;
      if (rst) begin
         for (int h = 0; h < N; h++) begin
            cnt[h]  = 0;
            pend[h] = 1'b0;
         end
         scan    = 1'b0;
         rr      = 0;
         exp_sel = 0;
         chk_sel = 1'b1;
         return;
      end
      for (int h = 0; h < N; h++) begin
         int p;
         p = int'(prescale[h*12 +: 12]);
         if (active[h] && cnt[h] >= p) begin
            exp_we[h] = 1'b1;
            exp_mt[h] = mtime_in[h*64 +: 64] +
                        64'(step[h*8 +: 8]);
            cnt[h] = 0;
         end else if (!active[h]) begin
            cnt[h] = 0;
         end else begin
            cnt[h] = cnt[h] + 1;
         end
      end
      ev = scan && (active != 4'b0);
      s = -1;
      bypend = 1'b0;
      if (ev) begin
         for (int h = 0; h < N; h++) begin
            if (s < 0 && active[h] && pend[h]) begin
               s = h;
               bypend = 1'b1;
            end
         end
         for (int k = 0; k < N; k++) begin
            int c;
            c = (rr + k) % N;
            if (s < 0 && active[c]) s = c;
         end
         if (!bypend) rr = (s + 1) % N;
         exp_intr[s] = mtime_in[s*64 +: 64] >= cmp_in[s*64 +: 64];
         exp_sel = s;
         chk_sel = 1'b1;
      end
      for (int h = 0; h < N; h++) begin
         bit np;
         np = pend[h] | upd[h];
         if (ev && h == s && !upd[h]) np = 1'b0;
         pend[h] = np;
      end
      scan = (active != 4'b0);
   endtask

   // one clock: predict, advance, compare, feed mtime back
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("we", 64'(we_o), 64'(exp_we));
      chk("intr", 64'(intr_o), 64'(exp_intr));
      for (int h = 0; h < N; h++) begin
         if (exp_we[h]) chk("mtime", mtime_o[h*64 +: 64], exp_mt[h]);
         if (exp_rst) chk("mtime_rst", mtime_o[h*64 +: 64], 64'd0);
      end
      if (chk_sel) chk("sel", 64'(sel_o), 64'(exp_sel));
      for (int h = 0; h < N; h++) begin
         if (exp_we[h]) mtime_in[h*64 +: 64] = exp_mt[h];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int ticks;
      int vals[$];
      int when[$];
      int seq[$];
      rst      = 1'b1;
      active   = '0;
      prescale = '0;
      step     = '0;
      mtime_in = '0;
      cmp_in   = '0;
      upd      = '0;
      cycle();
      cycle();
      chk("rst_we", 64'(we_o), 64'd0);
      chk("rst_intr", 64'(intr_o), 64'd0);
      chk("rst_sel", 64'(sel_o), 64'd0);
      chk("rst_mtime0", mtime_o[63:0], 64'd0);
      rst = 1'b0;

      // prescaler: tick every 4th cycle
      active = 4'b0001;
      prescale[11:0] = 12'd3;
      step[7:0] = 8'd1;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (we_o[0]) begin
            vals.push_back(int'(mtime_o[31:0]));
            when.push_back(i);
         end
      end
      chk("pre_nticks", 64'(vals.size()), 64'd4);
      if (vals.size() >= 3) begin
         chk("pre_v1", 64'(vals[0]), 64'd1);
         chk("pre_v2", 64'(vals[1]), 64'd2);
         chk("pre_v3", 64'(vals[2]), 64'd3);
         chk("pre_t1", 64'(when[0]), 64'd4);
         chk("pre_t2", 64'(when[1]), 64'd8);
      end
      active = 4'b0000;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (we_o[0]) ticks++;
      end
      chk("pre_off", 64'(ticks), 64'd0);

      // wrap and step 0
      active = 4'b0001;
      prescale[11:0] = 12'd0;
      step[7:0] = 8'd5;
      mtime_in[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
      cycle();
      chk("wrap_we", 64'(we_o[0]), 64'd1);
      chk("wrap_val", mtime_o[63:0], 64'd3);
      step[7:0] = 8'd0;
      cycle();
      chk("step0_we", 64'(we_o[0]), 64'd1);
      chk("step0_val", mtime_o[63:0], 64'd3);

      // compare hit, then raised by a compare write
      mtime_in[63:0] = 64'd100;
      cmp_in[63:0] = 64'd100;
      cycle();
      cycle();
      chk("cmp_hit", 64'(intr_o[0]), 64'd1);
      cmp_in[63:0] = 64'd101;
      upd = 4'b0001;
      cycle();
      upd = 4'b0000;
      chk("cmp_miss0", 64'(intr_o[0]), 64'd0);
      cycle();
      chk("cmp_miss1", 64'(intr_o[0]), 64'd0);

      // round robin over four, then without hart 2
      for (int h = 0; h < N; h++) begin
         mtime_in[h*64 +: 64] = 64'd100;
         cmp_in[h*64 +: 64] = 64'd0;
      end
      prescale = '0;
      step = '0;
      active = 4'b1111;
      do_reset();
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         seq.push_back(int'(sel_o));
         chk("rr_intr", 64'(intr_o), 64'(4'b0001 << sel_o));
      end
      chk("rr_s0", 64'(seq[0]), 64'd0);
      chk("rr_s1", 64'(seq[1]), 64'd1);
      chk("rr_s2", 64'(seq[2]), 64'd2);
      chk("rr_s3", 64'(seq[3]), 64'd3);
      chk("rr_s4", 64'(seq[4]), 64'd0);
      seq.delete();
      active = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         cycle();
         seq.push_back(int'(sel_o));
      end
      chk("rr3_s0", 64'(seq[0]), 64'd1);
      chk("rr3_s1", 64'(seq[1]), 64'd3);
      chk("rr3_s2", 64'(seq[2]), 64'd0);
      chk("rr3_s3", 64'(seq[3]), 64'd1);
      chk("rr3_s4", 64'(seq[4]), 64'd3);

      // pending priority with rr_ptr at 1
      seq.delete();
      active = 4'b1111;
      do_reset();
      cycle();
      upd = 4'b1000;
      cycle();
      seq.push_back(int'(sel_o));
      upd = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         cycle();
         seq.push_back(int'(sel_o));
      end
      chk("pp_s0", 64'(seq[0]), 64'd0);
      chk("pp_s1", 64'(seq[1]), 64'd3);
      chk("pp_s2", 64'(seq[2]), 64'd1);
      chk("pp_s3", 64'(seq[3]), 64'd2);

      // reset mid-scan with pending 1010
      active = 4'b0101;
      do_reset();
      cycle();
      upd = 4'b1010;
      cycle();
      upd = 4'b0000;
      cycle();
      active = 4'b1111;
      rst = 1'b1;
      cycle();
      chk("mr_we", 64'(we_o), 64'd0);
      chk("mr_intr", 64'(intr_o), 64'd0);
      chk("mr_sel", 64'(sel_o), 64'd0);
      rst = 1'b0;
      cycle();
      cycle();
      chk("mr_first", 64'(sel_o), 64'd0);
      cycle();
      chk("mr_second", 64'(sel_o), 64'd1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(299) == 0);
         upd = '0;
         if ($urandom_range(19) == 0) begin
            for (int h = 0; h < N; h++)
               active[h] = ($urandom_range(9) < 8);
            if ($urandom_range(9) == 0) active = '0;
         end
         if ($urandom_range(29) == 0) begin
            int h;
            h = $urandom_range(N - 1);
            prescale[h*12 +: 12] = 12'($urandom_range(4));
         end
         if ($urandom_range(29) == 0) begin
            int h;
            h = $urandom_range(N - 1);
            step[h*8 +: 8] = 8'($urandom_range(3));
         end
         if ($urandom_range(7) == 0) begin
            int h;
            h = $urandom_range(N - 1);
            cmp_in[h*64 +: 64] = mtime_in[h*64 +: 64] +
               64'($urandom_range(12)) - 64'd4;
            upd[h] = 1'b1;
         end
         if ($urandom_range(99) == 0) begin
            int h;
            h = $urandom_range(N - 1);
            mtime_in[h*64 +: 64] = {$urandom(), $urandom()};
         end
         cycle();
      end
      rst = 1'b0;
      upd = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
